// File: rtl/bit8_acc_unit_pkg.sv
// ---------------------------------------------------------------
// bit8_acc_unit_pkg : op codes, FSM states, multiply step count
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

package bit8_acc_unit_pkg;

  localparam int MUL_STEPS = 8;

  typedef enum logic [2:0] {
    OP_LOAD = 3'd0,
    OP_ADD  = 3'd1,
    OP_SUB  = 3'd2,
    OP_AND  = 3'd3,
    OP_OR   = 3'd4,
    OP_XOR  = 3'd5,
    OP_MUL  = 3'd6,
    OP_CLR  = 3'd7
  } op_t;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/bit8_shift_mul.sv
// ---------------------------------------------------------------
// bit8_shift_mul : iterative shift-add multiplier, one bit per cycle
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module bit8_shift_mul
  import bit8_acc_unit_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int STEPS = MUL_STEPS
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(STEPS);

  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] prod;
  logic [CW-1:0]      count;
  logic [2*WIDTH-1:0] addend;

  // done/product describe the step being taken this cycle, so the caller
  // can write the result on the same edge as the final iteration.
  assign addend  = mplier[0] ? ({{WIDTH{1'b0}}, mcand} << count) : '0;
  assign product = prod + addend;
  assign done    = busy && (count == CW'(STEPS - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      busy   <= 1'b0;
      mcand  <= '0;
      mplier <= '0;
      prod   <= '0;
      count  <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      mcand  <= multiplicand;
      mplier <= multiplier;
      prod   <= '0;
      count  <= '0;
    end else if (busy) begin
      prod   <= product;
      mplier <= mplier >> 1;
      count  <= count + 1'b1;
      if (done) busy <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/bit8_acc_unit.sv
// ---------------------------------------------------------------
// bit8_acc_unit : 8-bit accumulator/ALU stage with valid/ready input
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module bit8_acc_unit
  import bit8_acc_unit_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] acc_out,
  output logic             carry,
  output logic             zero,
  output logic             busy,
  output logic             done
);

  state_t             state, state_nxt;
  op_t                op_e;
  logic               accept;
  logic               mul_start;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_product;
  logic [WIDTH:0]     alu_res;

  assign op_e      = op_t'(op);
  assign in_ready  = (state == ST_IDLE);
  assign accept    = in_valid && in_ready;
  assign mul_start = accept && (op_e == OP_MUL);

  bit8_shift_mul #(
    .WIDTH (WIDTH),
    .STEPS (MUL_STEPS)
  ) u_mul (
    .clk          (clk),
    .reset        (reset),
    .start        (mul_start),
    .multiplicand (acc_out),
    .multiplier   (operand),
    .busy         (busy),
    .done         (mul_done),
    .product      (mul_product)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (mul_start) state_nxt = ST_MUL;
      ST_MUL:  if (mul_done)  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Bit WIDTH carries the ADD carry-out or the SUB borrow.
  always_comb begin
    alu_res = '0;
    case (op_e)
      OP_LOAD: alu_res = {1'b0, operand};
      OP_ADD:  alu_res = {1'b0, acc_out} + {1'b0, operand};
      OP_SUB:  alu_res = {1'b0, acc_out} - {1'b0, operand};
      OP_AND:  alu_res = {1'b0, acc_out & operand};
      OP_OR:   alu_res = {1'b0, acc_out | operand};
      OP_XOR:  alu_res = {1'b0, acc_out ^ operand};
      OP_MUL:  alu_res = '0;
      OP_CLR:  alu_res = '0;
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_out <= '0;
      carry   <= 1'b0;
      zero    <= 1'b1;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept && (op_e != OP_MUL)) begin
        acc_out <= alu_res[WIDTH-1:0];
        carry   <= alu_res[WIDTH];
        zero    <= (alu_res[WIDTH-1:0] == '0);
        done    <= 1'b1;
      end else if (mul_done) begin
        acc_out <= mul_product[WIDTH-1:0];
        carry   <= |mul_product[2*WIDTH-1:WIDTH];
        zero    <= (mul_product[WIDTH-1:0] == '0);
        done    <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bit8_acc_unit.sv
// ---------------------------------------------------------------
// tb_bit8_acc_unit : directed scoreboard bench for bit8_acc_unit
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module tb_bit8_acc_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] op;
  logic [7:0] operand;
  logic [7:0] acc_out;
  logic       carry;
  logic       zero;
  logic       busy;
  logic       done;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [7:0] acc;
    logic       carry;
    logic       zero;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] m_acc;
  logic       m_carry;

  always #5 clk = ~clk;

  bit8_acc_unit #(.WIDTH(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .operand  (operand),
    .acc_out  (acc_out),
    .carry    (carry),
    .zero     (zero),
    .busy     (busy),
    .done     (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour of one operation; result is queued for later comparison.
  task automatic model_push(input logic [2:0] o, input logic [7:0] b);
    logic [8:0]  r9;
    logic [15:0] p;
    r9 = 9'd0;
    case (o)
      3'b000: r9 = {1'b0, b};
      3'b001: r9 = m_acc + b;
      3'b010: r9 = {(m_acc < b), 8'(m_acc - b)};
      3'b011: r9 = {1'b0, m_acc & b};
      3'b100: r9 = {1'b0, m_acc | b};
      3'b101: r9 = {1'b0, m_acc ^ b};
      3'b110: begin
        p  = m_acc * b;
        r9 = {(p[15:8] != 8'd0), p[7:0]};
      end
      default: r9 = 9'd0;
    endcase
    m_acc   = r9[7:0];
    m_carry = r9[8];
    sb.push_back('{acc: m_acc, carry: m_carry, zero: (m_acc == 8'd0)});
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    chk({tag, "_done"}, done, 1);
    chk({tag, "_sb_nonempty"}, (sb.size() != 0), 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_acc"}, acc_out, e.acc);
      chk({tag, "_carry"}, carry, e.carry);
      chk({tag, "_zero"}, zero, e.zero);
    end
  endtask

  // Single-cycle op: drive, take one edge, compare against the scoreboard.
  task automatic do_op(input string tag, input logic [2:0] o, input logic [7:0] b);
    model_push(o, b);
    op = o; operand = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    pop_check(tag);
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
  endtask

  task automatic do_mul(input string tag, input logic [7:0] b);
    logic [7:0] pre_acc;
    pre_acc = m_acc;
    model_push(3'b110, b);
    op = 3'b110; operand = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({tag, "_busy_e0"}, busy, 1);
    chk({tag, "_rdy_e0"}, in_ready, 0);
    chk({tag, "_done_e0"}, done, 0);
    for (int i = 1; i <= 7; i++) begin
      in_valid = i[0];
      op = 3'b000; operand = 8'h55;
      @(posedge clk); #1;
      chk($sformatf("%s_busy_e%0d", tag, i), busy, 1);
      chk($sformatf("%s_rdy_e%0d", tag, i), in_ready, 0);
      chk($sformatf("%s_done_e%0d", tag, i), done, 0);
      chk($sformatf("%s_hold_e%0d", tag, i), acc_out, pre_acc);
    end
    in_valid = 1'b0;
    op = 3'b110; operand = b;
    @(posedge clk); #1;
    pop_check(tag);
    chk({tag, "_busy_e8"}, busy, 0);
    chk({tag, "_rdy_e8"}, in_ready, 1);
    idle_cycle();
    chk({tag, "_done_e9"}, done, 0);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; op = 3'b000; operand = 8'h00;
    m_acc = 8'h00; m_carry = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_acc", acc_out, 8'h00);
    chk("rst_zero", zero, 1);
    chk("rst_carry", carry, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    idle_cycle();
    chk("idle_done", done, 0);

    // Back-to-back accepts keep done high on consecutive cycles.
    do_op("load_f0", 3'b000, 8'hF0);
    do_op("add_20", 3'b001, 8'h20);
    idle_cycle();
    chk("add_done_low", done, 0);

    do_op("load_05", 3'b000, 8'h05);
    do_op("sub_05", 3'b010, 8'h05);
    do_op("sub_01", 3'b010, 8'h01);
    do_op("load_ff", 3'b000, 8'hFF);
    do_op("add_wrap", 3'b001, 8'h01);

    do_op("load_0c", 3'b000, 8'h0C);
    do_op("and_0a", 3'b011, 8'h0A);
    do_op("or_03", 3'b100, 8'h03);
    do_op("xor_0b", 3'b101, 8'h0B);
    do_op("load_a5", 3'b000, 8'hA5);
    do_op("clr", 3'b111, 8'h3C);
    idle_cycle();

    do_op("load_0d", 3'b000, 8'h0D);
    do_mul("mul_0b", 8'h0B);
    do_op("load_20", 3'b000, 8'h20);
    do_mul("mul_10", 8'h10);
    do_op("load_07", 3'b000, 8'h07);
    do_mul("mul_00", 8'h00);

    // Abort a multiply with reset on its fourth cycle.
    do_op("load_0d_b", 3'b000, 8'h0D);
    op = 3'b110; operand = 8'h0B; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) idle_cycle();
    chk("abort_busy_pre", busy, 1);
    reset = 1'b1;
    idle_cycle();
    reset = 1'b0;
    m_acc = 8'h00; m_carry = 1'b0;
    chk("abort_acc", acc_out, 8'h00);
    chk("abort_carry", carry, 0);
    chk("abort_zero", zero, 1);
    chk("abort_busy", busy, 0);
    chk("abort_ready", in_ready, 1);
    chk("abort_done", done, 0);
    for (int i = 0; i < 10; i++) begin
      idle_cycle();
      chk($sformatf("abort_no_done_%0d", i), done, 0);
      chk($sformatf("abort_acc_hold_%0d", i), acc_out, 8'h00);
    end

    do_op("post_abort_load", 3'b000, 8'h3C);
    chk("sb_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
